// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO and its read-side adapter.
package sync_fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef logic [DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/sync_fifo_reader_if.sv
// FIFO read port plus valid/ready output stream seen by sync_fifo_reader.
interface sync_fifo_reader_if #(
  parameter int unsigned DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  // Reader side: issues FIFO reads and sources the output stream.
  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_r_en,
    output m_valid,
    input  m_ready,
    output m_data
  );

  // Environment side: the FIFO read port and the downstream consumer.
  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_r_en,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry ordered buffer: pop shifts tail into head, push fills the first free slot.
module skid_buf2
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [SKID_CNT_W-1:0] cnt_o,
  output logic [WIDTH-1:0]      head_o,
  output logic [WIDTH-1:0]      tail_o
);

  logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic [WIDTH-1:0]      tail_q, tail_d;

  // Next state: flush wins; otherwise pop first, then write into the freed slot.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_i && (cnt_q != '0)) begin
        head_d = tail_q;
        cnt_d  = cnt_q - SKID_CNT_W'(1);
      end
      if (push_i && (cnt_d < SKID_CNT_W'(SKID_DEPTH))) begin
        if (cnt_d == '0) begin
          head_d = data_i;
        end else begin
          tail_d = data_i;
        end
        cnt_d = cnt_d + SKID_CNT_W'(1);
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = head_q;
  assign tail_o = tail_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// Pops words from a registered-output FIFO and presents them as a valid/ready stream.
module sync_fifo_reader #(
  parameter int unsigned DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = sync_fifo_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  sync_fifo_reader_if.master    bus,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  import sync_fifo_pkg::*;

  localparam int unsigned OCC_W = SKID_CNT_W + 1;

  logic                  inflight_q, inflight_d;
  logic                  discard_q, discard_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [OCC_W-1:0]      occ;
  logic                  out_fire;
  logic                  rd_accept;
  logic                  push;
  logic                  unused_tail;

  // Read issue, in-flight/discard tracking and delivered-word count.
  always_comb begin
    out_fire   = bus.m_valid && bus.m_ready;
    occ        = OCC_W'(buf_cnt) + OCC_W'(inflight_q) - OCC_W'(out_fire);
    rd_accept  = rst_n && !bus.fifo_empty && !flush && (occ < OCC_W'(SKID_DEPTH));
    push       = inflight_q && !discard_q;
    inflight_d = rd_accept;
    discard_d  = flush && (rd_accept || inflight_q);
    rd_count_d = rd_count_q;
    if (flush) begin
      rd_count_d = '0;
    end else if (out_fire) begin
      rd_count_d = rd_count_q + CNT_WIDTH'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_count_q <= rd_count_d;
    end
  end

  skid_buf2 #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (bus.fifo_data),
    .pop_i   (out_fire),
    .cnt_o   (buf_cnt),
    .head_o  (head),
    .tail_o  (tail)
  );

  // The second entry is only ever observed through the head after a pop.
  assign unused_tail = ^tail;

  assign bus.fifo_r_en = rd_accept;
  assign bus.m_valid   = (buf_cnt != '0);
  assign bus.m_data    = head;
  assign rd_count      = rd_count_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Randomized bench for sync_fifo_reader with a queue-based FIFO and stream model.
module tb_sync_fifo_reader;

  import sync_fifo_pkg::*;

  typedef fifo_word_t word_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] rd_count;

  sync_fifo_reader_if #(.DATA_WIDTH(8)) bus ();

  sync_fifo_reader #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total;
  int    bad;
  word_t fq[$];       // words held by the FIFO
  word_t exp_q[$];    // words read from the FIFO and not yet delivered, oldest first
  word_t out_log[$];  // words delivered on the output stream
  word_t words[$];
  int    cnt_m;
  int    n_acc;
  bit    acc_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load(input word_t w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: check just before the edge, then advance FIFO and model just after it.
  task automatic cyc(input bit wr = 1'b0, input word_t wd = '0);
    bit    acc, fire, exp_valid, exp_ren;
    word_t fire_data;
    word_t w;
    #8;
    exp_valid = exp_q.size() > (acc_last ? 1 : 0);
    check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
    exp_ren = rst_n && !bus.fifo_empty && !flush &&
              ((exp_q.size() - ((exp_valid && bus.m_ready) ? 1 : 0)) < 2);
    check("fifo_r_en", 32'(bus.fifo_r_en), 32'(exp_ren));
    check("rd_count", 32'(rd_count), 32'(16'(cnt_m)));
    acc       = bus.fifo_r_en && !bus.fifo_empty;
    fire      = bus.m_valid && bus.m_ready;
    fire_data = bus.m_data;
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
      cnt_m = 0;
    end else if (fire) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_log.push_back(fire_data);
      cnt_m++;
    end
    if (acc) begin
      w = fq.pop_front();
      bus.fifo_data = w;
      n_acc++;
      if (!flush) exp_q.push_back(w);
    end
    if (wr) fq.push_back(wd);
    bus.fifo_empty = (fq.size() == 0);
    check("occupancy", 32'(exp_q.size() <= 2), 32'd1);
    acc_last = acc && !flush;
  endtask

  task automatic drain(input int max_c, input bit toggle);
    int k;
    k = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && k < max_c) begin
      if (toggle) bus.m_ready = !bus.m_ready;
      cyc();
      k++;
    end
    check("drain_done", 32'(fq.size() + exp_q.size()), 32'd0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(out_log.size()), 32'(words.size()));
    for (int i = 0; i < words.size(); i++) begin
      if (i < out_log.size()) check(tag, 32'(out_log[i]), 32'(words[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total          = 0;
    bad            = 0;
    cnt_m          = 0;
    n_acc          = 0;
    acc_last       = 1'b0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.m_ready    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;

    // Reset values, with the FIFO already holding words.
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    #3;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_fifo_r_en", 32'(bus.fifo_r_en), 32'd0);

    // Streaming with no backpressure.
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    out_log.delete();
    repeat (6) cyc();
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_log("stream_order");
    check("stream_count", 32'(rd_count), 32'd4);
    check("stream_ren_empty", 32'(bus.fifo_r_en), 32'd0);
    check("stream_valid_end", 32'(bus.m_valid), 32'd0);

    // Backpressure: at most two words leave the FIFO while stalled.
    words.delete();
    for (int i = 0; i < 6; i++) begin
      words.push_back(word_t'($urandom_range(0, 255)));
      load(words[i]);
    end
    bus.m_ready = 1'b0;
    begin
      int n0;
      n0 = n_acc;
      repeat (10) cyc();
      check("stall_reads", 32'(n_acc - n0), 32'd2);
    end
    check("stall_valid", 32'(bus.m_valid), 32'd1);
    check("stall_head", 32'(bus.m_data), 32'(words[0]));
    check("stall_fifo_left", 32'(fq.size()), 32'd4);
    bus.m_ready = 1'b1;
    out_log.delete();
    drain(40, 1'b0);
    check_log("bp_order");
    check("bp_count", 32'(rd_count), 32'd10);

    // Idle flush clears the count; then alternating ready over 20 random words.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_idle_count", 32'(rd_count), 32'd0);
    words.delete();
    for (int i = 0; i < 20; i++) begin
      words.push_back(word_t'($urandom_range(0, 255)));
      load(words[i]);
    end
    out_log.delete();
    bus.m_ready = 1'b1;
    drain(200, 1'b1);
    check_log("alt_order");
    check("alt_count", 32'(rd_count), 32'd20);

    // Flush on the edge after a read is accepted: that word is dropped.
    bus.m_ready = 1'b1;
    words.delete();
    words.push_back(word_t'($urandom_range(0, 127)));
    words.push_back(word_t'($urandom_range(128, 255)));
    load(words[0]);
    load(words[1]);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_valid", 32'(bus.m_valid), 32'd0);
    check("flush_count", 32'(rd_count), 32'd0);
    out_log.delete();
    drain(20, 1'b0);
    void'(words.pop_front());
    check_log("flush_next");

    // Empty FIFO, idle, then refill with a single word.
    repeat (5) cyc();
    check("idle_ren", 32'(bus.fifo_r_en), 32'd0);
    cyc(1'b1, 8'hA5);
    cyc();
    cyc();
    check("refill_valid", 32'(bus.m_valid), 32'd1);
    check("refill_data", 32'(bus.m_data), 32'hA5);
    drain(10, 1'b0);

    // Asynchronous reset while the buffer is full.
    for (int i = 0; i < 5; i++) load(word_t'($urandom_range(0, 255)));
    bus.m_ready = 1'b1;
    repeat (4) cyc();
    bus.m_ready = 1'b0;
    repeat (4) cyc();
    check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    check("pre_rst_fifo_left", 32'(fq.size()), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(bus.m_valid), 32'd0);
    check("arst_fifo_r_en", 32'(bus.fifo_r_en), 32'd0);
    check("arst_rd_count", 32'(rd_count), 32'd0);
    fq.delete();
    exp_q.delete();
    cnt_m          = 0;
    acc_last       = 1'b0;
    bus.fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    check("arst_hold_valid", 32'(bus.m_valid), 32'd0);
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_reader.md
# sync_fifo_reader

Read-side adapter for the team's synchronous FIFO (`w_en`/`r_en`/`full`/`empty`, registered `data_out`). It pops words from the FIFO and presents them on a valid/ready output stream. A 2-entry skid buffer hides the FIFO's one-cycle read latency, so the block sustains one word per clock while the consumer holds `m_ready` high. It sits between the FIFO's read port and any downstream consumer, and also keeps a running count of words delivered.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `flush`  input  1  synchronous clear of buffered and in-flight words.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_data`  input  DATA_WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
- `fifo_r_en`  output  1  FIFO read enable; combinational.
- `m_valid`  output  1  output word valid.
- `m_ready`  input  1  consumer ready.
- `m_data`  output  DATA_WIDTH  output word (head of skid buffer).
- `rd_count`  output  CNT_WIDTH  words delivered since reset or flush; wraps modulo 2^CNT_WIDTH.

## Operation
- FIFO contract:
  - A read is accepted at a rising edge where `fifo_r_en && !fifo_empty`.
  - `fifo_data` holds that word from the same edge until the next accepted read.
- State:
  - `buf_cnt` (0..2) and two entries, `head` and `tail`.
  - `inflight`: a read was accepted on the previous edge, and its word is on `fifo_data` this cycle.
  - `discard`: the in-flight word must be dropped.
- `out_fire = m_valid && m_ready`.
- `fifo_r_en = !fifo_empty && !flush && (buf_cnt + inflight - out_fire) < 2`.
  - This never over-commits the buffer.
  - `fifo_r_en` is held 0 while `rst_n` is low.
- Capture: when `inflight && !discard`, the word on `fifo_data` enters the buffer at the next edge.
  - If `out_fire` occurs on the same edge, the buffer shifts first, then the word is written to the freed slot.
  - The relative order of words is always preserved.
- `m_valid = (buf_cnt != 0)`; `m_data = head`. Both are registered.
- `rd_count` increments by 1 on every `out_fire`.
- `flush` (sampled at an edge):
  - `buf_cnt` ← 0, `m_valid` ← 0, `rd_count` ← 0.
  - If a read was accepted on the flush edge or is in flight, `discard` ← 1, so that word is dropped on arrival.
  - No new read is issued in the flush cycle.
  - `out_fire` in the flush cycle is ignored.
- Once `m_valid` is high, `m_data` is stable until `out_fire`.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `rd_count` = 0, `fifo_r_en` = 0.
  - Internal state: `buf_cnt` = 0, `inflight` = 0, `discard` = 0.
- Latency: `fifo_r_en` accepted at edge N → `m_valid` high after edge N+1.
  - FIFO non-empty to first `m_valid` is two edges.
- Throughput: with `m_ready` constantly 1 and the FIFO never empty, one word per cycle after the initial latency.
- Backpressure with `m_ready` low:
  - At most 2 words are pulled from the FIFO, then `fifo_r_en` deasserts.
  - The FIFO keeps the rest.
- FIFO empty: `fifo_r_en` = 0; buffered words still drain.
- Async reset mid-transfer:
  - All state clears immediately.
  - A FIFO word accepted on the last edge before reset is lost.
  - Recovery requires resetting the FIFO together with this block.

## Structure
- Shared package `sync_fifo_pkg` holds:
  - `DATA_WIDTH` default.
  - `fifo_word_t` (`logic [DATA_WIDTH-1:0]`).
  - Skid-depth constant `SKID_DEPTH = 2`.
- One sub-module, `skid_buf2`: the 2-entry ordered buffer.
  - Push/pop/flush ports, plus `cnt`, `head` and `tail` outputs.
  - The top level holds the read-issue logic, `inflight`/`discard` tracking and `rd_count`.

## Test plan
- Streaming, no backpressure:
  - Stimulus: FIFO preloaded with 0x11, 0x22, 0x33, 0x44; `m_ready` = 1.
  - Response: `m_data` sequence 11,22,33,44 on four consecutive cycles, starting 2 edges after release; `rd_count` = 4; `fifo_r_en` drops once `fifo_empty` rises.
- Backpressure:
  - Stimulus: FIFO holds 6 words; `m_ready` = 0 for 10 cycles, then 1.
  - Response: exactly 2 reads accepted while stalled; `m_data` stable at word 0; all 6 words delivered in order.
- Alternating ready:
  - Stimulus: `m_ready` toggles every cycle over 20 random words.
  - Response: a scoreboard queue matches every word; no duplicates or drops; `rd_count` = 20.
- Flush with a read in flight:
  - Stimulus: assert `flush` for 1 cycle on the edge after a read is accepted.
  - Response: that word is never output; `m_valid` = 0 and `rd_count` = 0 after the edge; the next FIFO word is the first output.
- Empty/refill:
  - Stimulus: drain the FIFO to empty; idle 5 cycles; write 0xA5.
  - Response: `fifo_r_en` is 0 while empty; `m_data` = 0xA5 two edges after `fifo_empty` falls.
- Async reset mid-stream:
  - Stimulus: `rst_n` low between edges while `buf_cnt` = 2.
  - Response: `m_valid`, `fifo_r_en` and `rd_count` go to 0 immediately, without waiting for a clock edge.
